// File: rtl/bigint_sub_seq.sv
// ============================================================================
// Module      : bigint_sub_seq
// Description : Word-serial big-integer subtractor/comparator. Computes
//               d = a - b one WORD-bit limb per clock, LSB limb first, with a
//               registered borrow chain. Reports a >= b and a == b, and in
//               conditional mode returns (a >= b) ? a - b : a.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bigint_sub_seq #(
  parameter int WIDTH = 1024,
  parameter int WORD  = 32
) (
  input  logic             clk,
  input  logic             rst,     // asynchronous, active-low
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             aBigB,
  output logic             equal
);

  localparam int c_NW = WIDTH / WORD;
  localparam int c_IW = (c_NW > 1) ? $clog2(c_NW) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [WIDTH-1:0] r_a;        // captured minuend, rotated one limb per cycle
  logic [WIDTH-1:0] r_b;        // captured subtrahend, rotated one limb per cycle
  logic             r_mode;
  logic             r_borrow;
  logic             r_nz;       // any difference limb so far was nonzero
  logic [c_IW-1:0]  r_idx;

  logic [WIDTH-1:0] r_d;
  logic             r_abigb;
  logic             r_equal;

  logic             w_accept;
  logic             w_last;
  logic [WORD:0]    w_sub;
  logic [WORD-1:0]  w_diff;
  logic             w_nz_nxt;
  logic [WIDTH-1:0] w_a_rot;
  logic [WIDTH-1:0] w_b_rot;
  logic [WIDTH-1:0] w_full_diff;

  assign w_accept = ((r_state == c_IDLE) || (r_state == c_DONE)) && start;
  assign w_last   = (r_state == c_RUN) && (r_idx == c_IW'(c_NW - 1));

  // One limb of the subtraction; the extra top bit is the outgoing borrow.
  assign w_sub    = {1'b0, r_a[WORD-1:0]} - {1'b0, r_b[WORD-1:0]}
                  - {{WORD{1'b0}}, r_borrow};
  assign w_diff   = w_sub[WORD-1:0];
  assign w_nz_nxt = r_nz | (|w_diff);

  generate
    if (c_NW == 1) begin : g_single
      assign w_a_rot     = r_a;
      assign w_b_rot     = r_b;
      assign w_full_diff = w_diff;
    end else begin : g_multi
      // Completed lower limbs; the newest limb enters at the top.
      logic [WIDTH-WORD-1:0] r_acc;

      assign w_a_rot     = {r_a[WORD-1:0], r_a[WIDTH-1:WORD]};
      assign w_b_rot     = {r_b[WORD-1:0], r_b[WIDTH-1:WORD]};
      assign w_full_diff = {w_diff, r_acc};

      // Shift each finished difference limb into the accumulator.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_acc <= '0;
        end else if (r_state == c_RUN) begin
          r_acc <= (r_acc >> WORD) | ((WIDTH - WORD)'(w_diff) << (WIDTH - 2 * WORD));
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_nxt = c_RUN;
      c_RUN:   if (w_last) w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = start ? c_RUN : c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (r_state == c_RUN);
    done = (r_state == c_DONE);
  end

  // Operand capture, limb processing and result update at DONE entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_borrow <= 1'b0;
      r_nz     <= 1'b0;
      r_idx    <= '0;
      r_d      <= '0;
      r_abigb  <= 1'b0;
      r_equal  <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_mode   <= mode;
      r_borrow <= 1'b0;
      r_nz     <= 1'b0;
      r_idx    <= '0;
    end else if (r_state == c_RUN) begin
      r_a      <= w_a_rot;
      r_b      <= w_b_rot;
      r_borrow <= w_sub[WORD];
      r_nz     <= w_nz_nxt;
      r_idx    <= r_idx + c_IW'(1);
      if (w_last) begin
        // After the final rotation r_a is back to the captured minuend.
        r_d     <= (r_mode && w_sub[WORD]) ? w_a_rot : w_full_diff;
        r_abigb <= ~w_sub[WORD];
        r_equal <= ~w_nz_nxt;
      end
    end
  end

  assign d     = r_d;
  assign aBigB = r_abigb;
  assign equal = r_equal;

endmodule

`default_nettype wire

// File: tb/tb_bigint_sub_seq.sv
// ============================================================================
// Module      : tb_bigint_sub_seq
// Description : Self-checking bench for bigint_sub_seq. A small instance
//               (WIDTH=8, WORD=4) and a default instance (1024/32) share the
//               clock and reset; results are compared to a plain-arithmetic
//               model of unsigned subtraction and comparison.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bigint_sub_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        s_start = 1'b0, s_mode = 1'b0;
  logic [7:0]  s_a = '0, s_b = '0;
  logic        s_busy, s_done, s_abigb, s_equal;
  logic [7:0]  s_d;

  logic          b_start = 1'b0, b_mode = 1'b0;
  logic [1023:0] b_a = '0, b_b = '0;
  logic          b_busy, b_done, b_abigb, b_equal;
  logic [1023:0] b_d;

  int errors = 0;
  int checks = 0;

  bigint_sub_seq #(.WIDTH(8), .WORD(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .d(s_d), .aBigB(s_abigb), .equal(s_equal)
  );

  bigint_sub_seq u_big (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .a(b_a), .b(b_b),
    .busy(b_busy), .done(b_done), .d(b_d), .aBigB(b_abigb), .equal(b_equal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [1023:0] width_mask(input int w);
    logic [1023:0] m;
    m = '1;
    if (w < 1024) m = m >> (1024 - w);
    return m;
  endfunction

  // Reference: unsigned a - b modulo 2^w, or a itself in conditional mode when a < b.
  function automatic logic [1023:0] mdl_d(input int w, input logic [1023:0] a,
                                           input logic [1023:0] b, input bit m);
    if (m && (a < b)) return a;
    return (a - b) & width_mask(w);
  endfunction

  task automatic smp(input bit big, output logic bz, output logic dn,
                     output logic ab, output logic eq, output logic [1023:0] dd);
    if (big) begin
      bz = b_busy; dn = b_done; ab = b_abigb; eq = b_equal; dd = b_d;
    end else begin
      bz = s_busy; dn = s_done; ab = s_abigb; eq = s_equal; dd = {1016'd0, s_d};
    end
  endtask

  task automatic drive(input bit big, input bit st, input logic [1023:0] a,
                       input logic [1023:0] b, input bit m);
    if (big) begin
      b_start = st; b_a = a; b_b = b; b_mode = m;
    end else begin
      s_start = st; s_a = a[7:0]; s_b = b[7:0]; s_mode = m;
    end
  endtask

  // One operation: checks busy each RUN cycle, done timing, results, and done drop.
  task automatic run_op(input bit big, input logic [1023:0] a_in, input logic [1023:0] b_in,
                        input bit m, input string tag, input bit poke);
    int nw, w;
    logic [1023:0] a, b, dd;
    logic bz, dn, ab, eq;
    w  = big ? 1024 : 8;
    nw = big ? 32 : 2;
    a  = a_in & width_mask(w);
    b  = b_in & width_mask(w);
    @(negedge clk);
    drive(big, 1'b1, a, b, m);
    @(posedge clk); #1;
    drive(big, 1'b0, ~a, ~b, ~m);
    for (int c = 1; c <= nw; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      smp(big, bz, dn, ab, eq, dd);
      chk($sformatf("%s_busy_c%0d", tag, c), {1023'd0, bz}, 1024'd1);
      chk($sformatf("%s_done_c%0d", tag, c), {1023'd0, dn}, 1024'd0);
      if (poke && c == 1) drive(big, 1'b1, ~a, b >> 1, ~m);
      if (poke && c == 2) drive(big, 1'b0, ~a, b >> 1, ~m);
    end
    @(posedge clk); #1;
    smp(big, bz, dn, ab, eq, dd);
    chk({tag, "_done"}, {1023'd0, dn}, 1024'd1);
    chk({tag, "_busy_off"}, {1023'd0, bz}, 1024'd0);
    chk({tag, "_d"}, dd, mdl_d(w, a, b, m));
    chk({tag, "_aBigB"}, {1023'd0, ab}, {1023'd0, (a >= b)});
    chk({tag, "_equal"}, {1023'd0, eq}, {1023'd0, (a == b)});
    @(posedge clk); #1;
    smp(big, bz, dn, ab, eq, dd);
    chk({tag, "_done_drop"}, {1023'd0, dn}, 1024'd0);
    chk({tag, "_d_hold"}, dd, mdl_d(w, a, b, m));
  endtask

  initial begin
    logic [7:0]    ops_a[4], ops_b[4];
    logic [1023:0] ra, rb;

    // Reset state.
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", {1023'd0, s_busy}, 1024'd0);
    chk("rst_done", {1023'd0, s_done}, 1024'd0);
    chk("rst_d", {1016'd0, s_d}, 1024'd0);
    chk("rst_flags", {1022'd0, s_abigb, s_equal}, 1024'd0);
    chk("rst_big_d", b_d, 1024'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Directed small-width cases.
    run_op(1'b0, 8'hD8, 8'h5C, 1'b0, "basic", 1'b0);
    chk("basic_lit", {1016'd0, s_d}, 1024'h7C);
    run_op(1'b0, 8'h0B, 8'hC0, 1'b0, "wrap", 1'b0);
    chk("wrap_lit", {1016'd0, s_d}, 1024'h4B);
    run_op(1'b0, 8'h0B, 8'hC0, 1'b1, "cond_lt", 1'b0);
    chk("cond_lt_lit", {1016'd0, s_d}, 1024'h0B);
    run_op(1'b0, 8'hC0, 8'h0B, 1'b1, "cond_ge", 1'b0);
    chk("cond_ge_lit", {1016'd0, s_d}, 1024'hB5);
    run_op(1'b0, 8'h3C, 8'h3C, 1'b0, "equal", 1'b0);
    run_op(1'b0, 8'h10, 8'h01, 1'b0, "xborrow", 1'b0);
    chk("xborrow_lit", {1016'd0, s_d}, 1024'h0F);
    run_op(1'b0, 8'h9A, 8'h35, 1'b0, "ignore_start", 1'b1);

    // Start held high: back-to-back acceptances every 3 cycles.
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = 8'($urandom);
      ops_b[i] = 8'($urandom);
    end
    @(negedge clk);
    s_start = 1'b1; s_mode = 1'b0; s_a = ops_a[0]; s_b = ops_b[0];
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) begin
      s_a = ops_a[n+1]; s_b = ops_b[n+1];
      chk($sformatf("hold%0d_busy1", n), {1023'd0, s_busy}, 1024'd1);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_busy2", n), {1023'd0, s_busy}, 1024'd1);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_done", n), {1023'd0, s_done}, 1024'd1);
      chk($sformatf("hold%0d_d", n), {1016'd0, s_d}, mdl_d(8, {1016'd0, ops_a[n]}, {1016'd0, ops_b[n]}, 1'b0));
      if (n == 2) s_start = 1'b0;
      @(posedge clk); #1;
    end
    chk("hold_end_idle", {1022'd0, s_busy, s_done}, 1024'd0);

    // Randomized small-width operations.
    for (int i = 0; i < 16; i++) begin
      ra = {1016'd0, 8'($urandom)};
      rb = (i % 4 == 0) ? ra : {1016'd0, 8'($urandom)};
      run_op(1'b0, ra, rb, 1'($urandom), $sformatf("rnd%0d", i), 1'b0);
    end

    // Reset in cycle 1 of RUN, after a known nonzero result.
    run_op(1'b0, 8'hD8, 8'h5C, 1'b0, "pre_rst", 1'b0);
    @(negedge clk);
    s_start = 1'b1; s_a = 8'hF0; s_b = 8'h01; s_mode = 1'b0;
    @(posedge clk); #1;
    s_start = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("midrst_busy", {1023'd0, s_busy}, 1024'd0);
    chk("midrst_done", {1023'd0, s_done}, 1024'd0);
    chk("midrst_d", {1016'd0, s_d}, 1024'd0);
    chk("midrst_flags", {1022'd0, s_abigb, s_equal}, 1024'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst_nodone%0d", c), {1022'd0, s_done, s_busy}, 1024'd0);
    end
    run_op(1'b0, 8'h21, 8'h47, 1'b1, "after_rst", 1'b0);

    // Default-parameter instance.
    run_op(1'b1, '1, 1024'd1, 1'b0, "big_max", 1'b0);
    chk("big_max_lit", b_d, {{1023{1'b1}}, 1'b0});
    run_op(1'b1, 1024'd1, '1, 1'b0, "big_swap", 1'b0);
    chk("big_swap_lit", b_d, 1024'd2);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 32; k++) begin
        ra[k*32 +: 32] = $urandom;
        rb[k*32 +: 32] = (k == 31) ? ra[k*32 +: 32] : $urandom;
      end
      run_op(1'b1, ra, rb, 1'(i), $sformatf("big_rnd%0d", i), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
